flash_rom_fetch_ctrl: RTL and testbench

Sequences the SPI flash master so that 6809 reads in the ROM window are served from serial flash, and arbitrates flash ownership between the 6809 fetch path and the FT2232 programming path. It detects CPU ROM cycles and stretches them with MRDY until the byte arrives. It keeps a one-byte sequential prefetch buffer so consecutive opcode fetches avoid a full SPI transaction. It sits between the 6809 bus interface in `top` and `spi_flash_master`.

---
 rtl/flash_rom_fetch_ctrl.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_flash_rom_fetch_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_rom_fetch_ctrl.sv
// Serves 6809 ROM-window reads from SPI flash through a one-byte sequential prefetch buffer,
// and hands the flash pins to the FT2232 programmer when the CPU path is idle.
module flash_rom_fetch_ctrl #(
  parameter logic [15:0] ROM_BASE     = 16'hE000,
  parameter logic [23:0] FLASH_OFFSET = 24'h000000,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] i_addr,
  input  logic        i_rw,
  input  logic        i_e,
  input  logic        i_q,
  input  logic        i_ft_cs_n,
  output logic        o_rd_start,
  output logic [23:0] o_rd_addr,
  input  logic        i_rd_busy,
  input  logic        i_rd_valid,
  input  logic [7:0]  i_rd_data,
  output logic [7:0]  o_rom_data,
  output logic        o_rom_oe,
  output logic        o_mrdy,
  output logic        o_sel_ft,
  output logic        o_err
);

  typedef enum logic [2:0] {StIdle, StFetch, StHold, StPrefetch, StProg} state_e;

  state_e      state_q, state_d;
  logic        e_meta_q, e_sync_q, e_prev_q;
  logic        q_meta_q, q_sync_q, q_prev_q;
  logic        rw_meta_q, rw_sync_q;
  logic        req_q;
  logic [15:0] addr_q;
  logic        rd_start_q, rd_start_d;
  logic [23:0] rd_addr_q, rd_addr_d;
  logic [7:0]  rom_data_q, rom_data_d;
  logic        rom_oe_q, rom_oe_d;
  logic        mrdy_q, mrdy_d;
  logic        sel_ft_q, sel_ft_d;
  logic        err_q, err_d;
  logic        pf_valid_q, pf_valid_d;
  logic [15:0] pf_addr_q, pf_addr_d;
  logic [7:0]  pf_data_q, pf_data_d;
  logic        issued_q, issued_d;
  logic        pend_q, pend_d;
  logic        serve_q, serve_d;
  logic [7:0]  tmr_q, tmr_d;
  logic [3:0]  ft_cnt_q, ft_cnt_d;

  logic        q_rise, e_fall;
  logic        got, tout, done, hit, pending, launch;
  logic [23:0] launch_addr;
  logic [7:0]  byte_in;

  function automatic logic [23:0] flash_addr(input logic [15:0] a);
    logic [15:0] off;
    off = a - ROM_BASE;
    return FLASH_OFFSET + {8'h00, off};
  endfunction

  assign q_rise = q_sync_q & ~q_prev_q;
  assign e_fall = ~e_sync_q & e_prev_q;

  // Bus-side synchronizers and request detection; addr_q holds the latest request address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_meta_q  <= 1'b0;
      e_sync_q  <= 1'b0;
      e_prev_q  <= 1'b0;
      q_meta_q  <= 1'b0;
      q_sync_q  <= 1'b0;
      q_prev_q  <= 1'b0;
      rw_meta_q <= 1'b0;
      rw_sync_q <= 1'b0;
      req_q     <= 1'b0;
      addr_q    <= 16'h0000;
    end else begin
      e_meta_q  <= i_e;
      e_sync_q  <= e_meta_q;
      e_prev_q  <= e_sync_q;
      q_meta_q  <= i_q;
      q_sync_q  <= q_meta_q;
      q_prev_q  <= q_sync_q;
      rw_meta_q <= i_rw;
      rw_sync_q <= rw_meta_q;
      req_q     <= q_rise && rw_sync_q && (i_addr >= ROM_BASE);
      if (q_rise) addr_q <= i_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rd_start_q <= 1'b0;
      rd_addr_q  <= 24'h000000;
      rom_data_q <= 8'hFF;
      rom_oe_q   <= 1'b0;
      mrdy_q     <= 1'b1;
      sel_ft_q   <= 1'b0;
      err_q      <= 1'b0;
      pf_valid_q <= 1'b0;
      pf_addr_q  <= 16'h0000;
      pf_data_q  <= 8'hFF;
      issued_q   <= 1'b0;
      pend_q     <= 1'b0;
      serve_q    <= 1'b0;
      tmr_q      <= 8'h00;
      ft_cnt_q   <= 4'h0;
    end else begin
      state_q    <= state_d;
      rd_start_q <= rd_start_d;
      rd_addr_q  <= rd_addr_d;
      rom_data_q <= rom_data_d;
      rom_oe_q   <= rom_oe_d;
      mrdy_q     <= mrdy_d;
      sel_ft_q   <= sel_ft_d;
      err_q      <= err_d;
      pf_valid_q <= pf_valid_d;
      pf_addr_q  <= pf_addr_d;
      pf_data_q  <= pf_data_d;
      issued_q   <= issued_d;
      pend_q     <= pend_d;
      serve_q    <= serve_d;
      tmr_q      <= tmr_d;
      ft_cnt_q   <= ft_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rd_start_d  = 1'b0;
    rd_addr_d   = rd_addr_q;
    rom_data_d  = rom_data_q;
    rom_oe_d    = 1'b0;
    mrdy_d      = mrdy_q;
    sel_ft_d    = sel_ft_q;
    err_d       = err_q;
    pf_valid_d  = pf_valid_q;
    pf_addr_d   = pf_addr_q;
    pf_data_d   = pf_data_q;
    issued_d    = issued_q;
    pend_d      = pend_q;
    serve_d     = serve_q;
    tmr_d       = tmr_q;
    ft_cnt_d    = ft_cnt_q;
    launch      = 1'b0;
    launch_addr = rd_addr_q;

    // A read only completes (byte or timeout) once its start pulse has actually gone out.
    got     = issued_q && i_rd_valid;
    tout    = issued_q && !i_rd_valid && (tmr_q == 8'(TIMEOUT));
    done    = got || tout;
    byte_in = got ? i_rd_data : 8'hFF;
    hit     = pf_valid_q && (pf_addr_q == addr_q);
    pending = pend_q || req_q;
    if (issued_q && !done) tmr_d = tmr_q + 8'd1;

    unique case (state_q)
      StIdle: begin
        if (req_q) begin
          if (hit) begin
            rom_data_d = pf_data_q;
            mrdy_d     = 1'b1;
            state_d    = StHold;
          end else begin
            mrdy_d      = 1'b0;
            launch      = 1'b1;
            launch_addr = flash_addr(addr_q);
            state_d     = StFetch;
          end
        end else if (!i_ft_cs_n && !i_rd_busy) begin
          sel_ft_d = 1'b1;
          ft_cnt_d = 4'h0;
          serve_d  = 1'b0;
          state_d  = StProg;
        end
      end
      StFetch: begin
        if (!issued_q && !i_rd_busy) begin
          rd_start_d = 1'b1;
          issued_d   = 1'b1;
          tmr_d      = 8'h00;
        end
        if (done) begin
          issued_d   = 1'b0;
          rom_data_d = byte_in;
          pf_data_d  = byte_in;
          mrdy_d     = 1'b1;
          state_d    = StHold;
          if (tout) begin
            err_d      = 1'b1;
            pf_valid_d = 1'b0;
          end
        end
      end
      StHold: begin
        rom_oe_d = e_sync_q;
        if (e_fall) begin
          if (addr_q != 16'hFFFF) begin
            launch      = 1'b1;
            launch_addr = flash_addr(addr_q + 16'd1);
            pf_addr_d   = addr_q + 16'd1;
            pf_valid_d  = 1'b0;
            pend_d      = 1'b0;
            state_d     = StPrefetch;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StPrefetch: begin
        if (!issued_q && !i_rd_busy) begin
          rd_start_d = 1'b1;
          issued_d   = 1'b1;
          tmr_d      = 8'h00;
        end
        if (req_q) begin
          pend_d = 1'b1;
          mrdy_d = 1'b0;
        end
        if (done) begin
          issued_d   = 1'b0;
          pend_d     = 1'b0;
          pf_data_d  = byte_in;
          pf_valid_d = got;
          if (tout) err_d = 1'b1;
          if (!pending) begin
            state_d = StIdle;
          end else if (addr_q == pf_addr_q) begin
            rom_data_d = byte_in;
            mrdy_d     = 1'b1;
            state_d    = StHold;
          end else begin
            pf_valid_d  = 1'b0;
            mrdy_d      = 1'b0;
            launch      = 1'b1;
            launch_addr = flash_addr(addr_q);
            state_d     = StFetch;
          end
        end
      end
      StProg: begin
        // The CPU still gets a completed cycle while the programmer owns the flash.
        if (req_q) begin
          rom_data_d = 8'hFF;
          serve_d    = 1'b1;
        end
        rom_oe_d = (serve_q || req_q) && e_sync_q;
        if (e_fall) serve_d = 1'b0;
        if (i_ft_cs_n) begin
          if (ft_cnt_q == 4'd15) begin
            sel_ft_d   = 1'b0;
            pf_valid_d = 1'b0;
            serve_d    = 1'b0;
            rom_oe_d   = 1'b0;
            state_d    = StIdle;
          end else begin
            ft_cnt_d = ft_cnt_q + 4'd1;
          end
        end else begin
          ft_cnt_d = 4'h0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (launch) begin
      rd_addr_d = launch_addr;
      issued_d  = 1'b0;
      if (!i_rd_busy) begin
        rd_start_d = 1'b1;
        issued_d   = 1'b1;
        tmr_d      = 8'h00;
      end
    end
  end

  assign o_rd_start = rd_start_q;
  assign o_rd_addr  = rd_addr_q;
  assign o_rom_data = rom_data_q;
  assign o_rom_oe   = rom_oe_q;
  assign o_mrdy     = mrdy_q;
  assign o_sel_ft   = sel_ft_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_flash_rom_fetch_ctrl.sv
// Scoreboard bench: expected flash requests and served bytes are queued by the stimulus and
// consumed by a monitor; a behavioural SPI flash answers each read after a set latency.
module tb_flash_rom_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] i_addr;
  logic        i_rw, i_e, i_q, i_ft_cs_n;
  logic        o_rd_start;
  logic [23:0] o_rd_addr;
  logic        i_rd_busy, i_rd_valid;
  logic [7:0]  i_rd_data;
  logic [7:0]  o_rom_data;
  logic        o_rom_oe, o_mrdy, o_sel_ft, o_err;

  int tests = 0;
  int fails = 0;
  int lat = 4;
  bit withhold = 1'b0;
  int low_cnt;
  int lows;

  logic [23:0] exp_start_q[$];
  logic [7:0]  exp_data_q[$];

  always #5 clk = ~clk;

  flash_rom_fetch_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_addr     (i_addr),
    .i_rw       (i_rw),
    .i_e        (i_e),
    .i_q        (i_q),
    .i_ft_cs_n  (i_ft_cs_n),
    .o_rd_start (o_rd_start),
    .o_rd_addr  (o_rd_addr),
    .i_rd_busy  (i_rd_busy),
    .i_rd_valid (i_rd_valid),
    .i_rd_data  (i_rd_data),
    .o_rom_data (o_rom_data),
    .o_rom_oe   (o_rom_oe),
    .o_mrdy     (o_mrdy),
    .o_sel_ft   (o_sel_ft),
    .o_err      (o_err)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    return 8'hA5 ^ a[7:0] ^ a[15:8];
  endfunction

  // Flash model: busy for the read, one-cycle valid pulse unless withheld.
  initial begin
    logic [23:0] fa;
    i_rd_busy  = 1'b0;
    i_rd_valid = 1'b0;
    i_rd_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (o_rd_start) begin
        fa        = o_rd_addr;
        i_rd_busy = 1'b1;
        repeat (lat - 1) @(negedge clk);
        if (!withhold) begin
          i_rd_data  = flash_byte(fa);
          i_rd_valid = 1'b1;
        end
        @(negedge clk);
        i_rd_valid = 1'b0;
        i_rd_busy  = 1'b0;
      end
    end
  end

  // Monitor: every start pulse and every rising o_rom_oe consumes one expectation.
  initial begin
    logic oe_prev;
    oe_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (o_rd_start) begin
        if (exp_start_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rd_start_unexpected: got addr %h, required no request", o_rd_addr);
        end else begin
          check("rd_addr", {8'h00, o_rd_addr}, {8'h00, exp_start_q.pop_front()});
        end
      end
      if (o_rom_oe && !oe_prev) begin
        check("mrdy_high_while_driving", {31'd0, o_mrdy}, 32'd1);
        if (exp_data_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rom_oe_unexpected: got data %h, required no drive", o_rom_data);
        end else begin
          check("rom_data", {24'h0, o_rom_data}, {24'h0, exp_data_q.pop_front()});
        end
      end
      oe_prev = o_rom_oe;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, required end of test");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    if (!o_mrdy) low_cnt++;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // One 6809 read cycle; E stays high while MRDY stretches it. Returns MRDY-low cycle count.
  task automatic cpu_read(input logic [15:0] a, output int low_cycles);
    int guard;
    low_cnt = 0;
    i_addr  = a;
    i_rw    = 1'b1;
    i_q     = 1'b1;
    repeat (3) tick();
    i_e = 1'b1;
    repeat (3) tick();
    i_q   = 1'b0;
    guard = 0;
    tick();
    while (!o_mrdy && guard < 600) begin
      tick();
      guard++;
    end
    if (!o_mrdy) begin
      tests++;
      fails++;
      $display("FAIL mrdy_release_bound: got mrdy %b after %0d cycles, required 1", o_mrdy, guard);
    end
    repeat (3) tick();
    i_e = 1'b0;
    repeat (3) tick();
    low_cycles = low_cnt;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rom_data"}, {24'h0, o_rom_data}, 32'hFF);
    check({tag, "_rom_oe"},   {31'd0, o_rom_oe},   32'd0);
    check({tag, "_mrdy"},     {31'd0, o_mrdy},     32'd1);
    check({tag, "_sel_ft"},   {31'd0, o_sel_ft},   32'd0);
    check({tag, "_err"},      {31'd0, o_err},      32'd0);
    check({tag, "_rd_start"}, {31'd0, o_rd_start}, 32'd0);
    check({tag, "_rd_addr"},  {8'h00, o_rd_addr},  32'd0);
  endtask

  initial begin
    i_addr    = 16'h0000;
    i_rw      = 1'b1;
    i_e       = 1'b0;
    i_q       = 1'b0;
    i_ft_cs_n = 1'b1;
    rst_n     = 1'b0;
    low_cnt   = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    idle(4);

    // Cold miss at the window base, then sequential prefetch of E001.
    exp_start_q.push_back(24'h000000);
    exp_data_q.push_back(8'hA5);
    exp_start_q.push_back(24'h000001);
    cpu_read(16'hE000, lows);
    check("e000_miss_mrdy_low", {31'd0, lows != 0}, 32'd1);
    idle(12);

    // Programmer takes the flash; CPU reads see FF without stretching.
    i_ft_cs_n = 1'b0;
    idle(3);
    check("prog_sel_ft", {31'd0, o_sel_ft}, 32'd1);
    exp_data_q.push_back(8'hFF);
    cpu_read(16'hE001, lows);
    check("prog_read_mrdy_cycles", lows, 0);
    i_ft_cs_n = 1'b1;
    idle(15);
    check("prog_hold_15", {31'd0, o_sel_ft}, 32'd1);
    idle(1);
    check("prog_exit_16", {31'd0, o_sel_ft}, 32'd0);

    // Buffer was invalidated on exit, so E001 misses.
    exp_start_q.push_back(24'h000001);
    exp_data_q.push_back(8'hA4);
    exp_start_q.push_back(24'h000002);
    cpu_read(16'hE001, lows);
    check("e001_after_prog_miss", {31'd0, lows != 0}, 32'd1);
    idle(12);

    // Sequential hit; slow flash so the next prefetch is still pending for the F000 read.
    lat = 20;
    exp_data_q.push_back(8'hA7);
    exp_start_q.push_back(24'h000003);
    cpu_read(16'hE002, lows);
    check("e002_hit_mrdy_cycles", lows, 0);

    exp_start_q.push_back(24'h001000);
    exp_data_q.push_back(8'hB5);
    exp_start_q.push_back(24'h001001);
    cpu_read(16'hF000, lows);
    check("f000_during_prefetch_mrdy_low", {31'd0, lows != 0}, 32'd1);
    idle(40);
    lat = 4;
    check("err_clear_before_timeout", {31'd0, o_err}, 32'd0);

    // Withheld flash response: timeout serves FF and flags o_err.
    withhold = 1'b1;
    exp_start_q.push_back(24'h000010);
    exp_data_q.push_back(8'hFF);
    exp_start_q.push_back(24'h000011);
    cpu_read(16'hE010, lows);
    withhold = 1'b0;
    check("timeout_mrdy_cycles", lows, 256);
    check("timeout_err", {31'd0, o_err}, 32'd1);
    idle(12);
    exp_data_q.push_back(8'hB4);
    exp_start_q.push_back(24'h000012);
    cpu_read(16'hE011, lows);
    check("e011_hit_mrdy_cycles", lows, 0);
    idle(12);
    check("err_sticky", {31'd0, o_err}, 32'd1);

    // Reset in the middle of a fetch; the late flash byte must be ignored.
    lat = 30;
    exp_start_q.push_back(24'h000020);
    i_addr = 16'hE020;
    i_q    = 1'b1;
    repeat (3) tick();
    i_e = 1'b1;
    repeat (4) tick();
    check("fetch_stretching", {31'd0, o_mrdy}, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    i_q = 1'b0;
    i_e = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(40);
    check("late_valid_mrdy", {31'd0, o_mrdy}, 32'd1);
    check("late_valid_oe", {31'd0, o_rom_oe}, 32'd0);
    check("late_valid_rom_data", {24'h0, o_rom_data}, 32'hFF);
    check("late_valid_rd_addr", {8'h00, o_rd_addr}, 32'd0);
    lat = 4;

    exp_start_q.push_back(24'h000020);
    exp_data_q.push_back(8'h85);
    exp_start_q.push_back(24'h000021);
    cpu_read(16'hE020, lows);
    check("e020_after_reset_miss", {31'd0, lows != 0}, 32'd1);
    idle(12);

    check("start_queue_drained", exp_start_q.size(), 0);
    check("data_queue_drained", exp_data_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
